// File: rtl/olink_rx_aligner_if.sv
// rtl/olink_rx_aligner_if.sv - link-side bundle: decoded input words in, packed words out
interface olink_rx_aligner_if #(
  parameter int BYTES_IN = 2,
  parameter int RATIO    = 2
);
  localparam int DW = 8 * BYTES_IN;
  localparam int W  = DW * RATIO;
  localparam int KW = BYTES_IN * RATIO;

  // decoded transceiver words
  logic [DW-1:0]       rx_d_i;
  logic [BYTES_IN-1:0] rx_k_i;
  logic [BYTES_IN-1:0] rx_nit_i;
  logic                rx_ready;

  // packed, aligned words
  logic [W-1:0]        rx_d;
  logic [KW-1:0]       rx_k;
  logic                rx_v;
  logic                rx_stb;

  // the aligner drives the packed side and consumes the decoded side
  modport master (
    input  rx_d_i, rx_k_i, rx_nit_i, rx_ready,
    output rx_d, rx_k, rx_v, rx_stb
  );

  modport slave (
    output rx_d_i, rx_k_i, rx_nit_i, rx_ready,
    input  rx_d, rx_k, rx_v, rx_stb
  );
endinterface

// File: rtl/olink_rx_aligner.sv
// rtl/olink_rx_aligner.sv - comma aligner packing RATIO input words per output word
// Optional spy capture buffer compiled in with macro OLINK_RX_SPY_EN.
module olink_rx_aligner #(
  parameter int         BYTES_IN = 2,
  parameter int         RATIO    = 2,
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter logic [7:0] PAD      = 8'h1C,
  parameter int         MAX_BAD  = 16,
  parameter int         SPY_AW   = 6
) (
  input  logic                  clk_link,
  input  logic                  reset,
  olink_rx_aligner_if.master    lnk,
  input  logic                  counter_reset,
  input  logic                  spy_start,
  input  logic [SPY_AW-1:0]     spy_raddr,
  output logic [31:0]           spy_rdata,
  output logic                  spy_done,
  output logic                  locked,
  output logic [31:0]           count_bad,
  output logic [15:0]           count_realign
);
  localparam int DW = 8 * BYTES_IN;
  localparam int W  = DW * RATIO;
  localparam int KW = BYTES_IN * RATIO;
  localparam int PW = $clog2(RATIO);
  localparam int BW = $clog2(MAX_BAD + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                         state;
  logic [PW-1:0]                  phase;
  logic [PW-1:0]                  eff_phase;
  logic [PW-1:0]                  next_phase;
  logic [BW-1:0]                  bad_run;
  logic [RATIO-2:0][DW-1:0]       acc_d;
  logic [RATIO-2:0][BYTES_IN-1:0] acc_k;
  logic                           grp_ok;
  logic                           grp_lk;
  logic                           grp_fc;
  logic                           ok;
  logic                           comma;
  logic                           realign;
  logic                           word_lk;
  logic                           last;
  logic                           lose_lock;
  logic [W-1:0]                   grp_d;
  logic [KW-1:0]                  grp_k;
  logic [W-1:0]                   pack_d;
  logic [KW-1:0]                  pack_k;
  logic [W-1:0]                   d_q;
  logic [KW-1:0]                  k_q;
  logic                           v_q;
  logic                           stb_q;

  // word classification, phase forcing and the packed group candidate
  always_comb begin
    ok         = (lnk.rx_nit_i == '0) && lnk.rx_ready;
    comma      = (lnk.rx_k_i == BYTES_IN'(1)) && (lnk.rx_d_i[7:0] == COMMA);
    realign    = comma && (state == LOCKED) && (phase != '0);
    // a comma always starts a group, whether it locks, realigns or is already at phase 0
    eff_phase  = comma ? '0 : phase;
    last       = (eff_phase == PW'(RATIO - 1));
    next_phase = last ? '0 : eff_phase + 1'b1;
    // the locking comma itself counts as a locked word so its group is valid
    word_lk    = (state == LOCKED) || comma;
    lose_lock  = !ok && (bad_run == BW'(MAX_BAD - 1));
    grp_d      = {lnk.rx_d_i, acc_d};
    grp_k      = {lnk.rx_k_i, acc_k};
    if (grp_fc || (grp_k == '0) || (grp_k == '1)) begin
      pack_d = grp_d;
      pack_k = grp_k;
    end else begin
      pack_d = {(W/8){PAD}};
      pack_k = '1;
    end
  end

  // lock state, phase tracking, group accumulation and output load
  always_ff @(posedge clk_link) begin
    if (reset) begin
      state   <= HUNT;
      phase   <= '0;
      bad_run <= '0;
      acc_d   <= '0;
      acc_k   <= '0;
      grp_ok  <= 1'b0;
      grp_lk  <= 1'b0;
      grp_fc  <= 1'b0;
      d_q     <= '0;
      k_q     <= '0;
      v_q     <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      phase <= next_phase;
      stb_q <= 1'b0;
      if (lose_lock) begin
        state <= HUNT;
      end else if (comma) begin
        state <= LOCKED;
      end
      if (ok || lose_lock) begin
        bad_run <= '0;
      end else begin
        bad_run <= bad_run + 1'b1;
      end
      if (eff_phase == '0) begin
        grp_ok <= ok;
        grp_lk <= word_lk;
        grp_fc <= comma;
      end else begin
        grp_ok <= grp_ok && ok;
        grp_lk <= grp_lk && word_lk;
      end
      for (int i = 0; i < RATIO - 1; i++) begin
        if (eff_phase == PW'(i)) begin
          acc_d[i] <= lnk.rx_d_i;
          acc_k[i] <= lnk.rx_k_i;
        end
      end
      if (last && grp_lk && word_lk) begin
        stb_q <= 1'b1;
        d_q   <= pack_d;
        k_q   <= pack_k;
        v_q   <= grp_ok && ok;
      end
    end
  end

  // saturating error counters; clearing wins over a same-cycle increment
  always_ff @(posedge clk_link) begin
    if (reset || counter_reset) begin
      count_bad     <= '0;
      count_realign <= '0;
    end else begin
      if (!ok && (count_bad != '1)) begin
        count_bad <= count_bad + 1'b1;
      end
      if (realign && (count_realign != '1)) begin
        count_realign <= count_realign + 1'b1;
      end
    end
  end

  assign lnk.rx_d   = d_q;
  assign lnk.rx_k   = k_q;
  assign lnk.rx_v   = v_q;
  assign lnk.rx_stb = stb_q;
  assign locked     = (state == LOCKED);

`ifdef OLINK_RX_SPY_EN
  localparam int D = 2 ** SPY_AW;

  logic [31:0]       spy_mem [D];
  logic [SPY_AW-1:0] spy_wptr;
  logic              spy_active;
  logic              spy_done_q;

  // capture pointer: restart on spy_start, stop after the last entry
  always_ff @(posedge clk_link) begin
    if (reset) begin
      spy_wptr   <= '0;
      spy_active <= 1'b0;
      spy_done_q <= 1'b0;
    end else if (spy_start) begin
      spy_wptr   <= '0;
      spy_active <= 1'b1;
      spy_done_q <= 1'b0;
    end else if (spy_active) begin
      spy_wptr <= spy_wptr + 1'b1;
      if (spy_wptr == SPY_AW'(D - 1)) begin
        spy_active <= 1'b0;
        spy_done_q <= 1'b1;
      end
    end
  end

  // buffer write of the raw input word and registered read port
  always_ff @(posedge clk_link) begin
    if (spy_active && !spy_start && !reset) begin
      spy_mem[spy_wptr] <= 32'({lnk.rx_nit_i, lnk.rx_k_i, lnk.rx_d_i});
    end
    spy_rdata <= spy_mem[spy_raddr];
  end

  assign spy_done = spy_done_q;
`else
  logic spy_unused;

  assign spy_rdata  = '0;
  assign spy_done   = 1'b0;
  assign spy_unused = &{1'b0, spy_start, spy_raddr};
`endif
endmodule
